// File: rtl/memory_cycle.sv
// Memory (M) stage of the five-stage RISC-V pipeline.
// Holds the byte-lane data memory and the M/W pipeline register. Loads read
// the addressed word combinationally, then extend it. Stores commit on the
// clock edge. The W register clears asynchronously when reset goes low.
module memory_cycle #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  StoreM,
  input  logic [2:0]  LoadM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] luipacM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RDM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] luipacW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RDW,
  output logic        MisalignW
);

  localparam int Depth = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] wordIdx;
  logic [1:0]            byteOff;
  logic [3:0]            laneWe;
  logic [31:0]           laneData;
  logic [31:0]           readWord;
  logic [31:0]           loadData;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;
  logic                  storeMisalignRaw;
  logic                  storeMisalign;
  logic                  loadMisalign;
  logic                  misalignM;

  // Upper address bits are dropped, so accesses wrap around the memory.
  assign wordIdx = ALUResultM[DEPTH_LOG2+1:2];
  assign byteOff = ALUResultM[1:0];

  // Store decode: replicate the data onto every lane and pick lanes by size and offset.
  always_comb begin
    laneWe           = 4'b0000;
    laneData         = WriteDataM;
    storeMisalignRaw = 1'b0;
    case (StoreM)
      2'b01: begin
        laneData         = {2{WriteDataM[15:0]}};
        storeMisalignRaw = byteOff[0];
        laneWe           = byteOff[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        laneData = {4{WriteDataM[7:0]}};
        laneWe   = 4'b0001 << byteOff;
      end
      default: begin
        storeMisalignRaw = (byteOff != 2'b00);
        laneWe           = 4'b1111;
      end
    endcase
    storeMisalign = MemWriteM & storeMisalignRaw;
    if (!MemWriteM || storeMisalignRaw) begin
      laneWe = 4'b0000;
    end
  end

  // One memory array per byte lane. Lane gi holds bits [8gi+7:8gi].
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    logic [7:0] laneMem [Depth];

    // Commit enabled lanes. Nothing is written while reset is held low.
    always_ff @(posedge clk) begin
      if (reset && laneWe[gi]) begin
        laneMem[wordIdx] <= laneData[8*gi +: 8];
      end
    end

    assign readWord[8*gi +: 8] = laneMem[wordIdx];
  end

  assign byteSel = readWord[8*byteOff +: 8];
  assign halfSel = readWord[16*byteOff[1] +: 16];

  // Load extension. Misaligned halfword and word loads yield zero data.
  always_comb begin
    loadData     = readWord;
    loadMisalign = 1'b0;
    case (LoadM)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadData = {24'h0, byteSel};
      3'b001: begin
        loadMisalign = byteOff[0];
        loadData     = {{16{halfSel[15]}}, halfSel};
      end
      3'b101: begin
        loadMisalign = byteOff[0];
        loadData     = {16'h0, halfSel};
      end
      default: loadMisalign = (byteOff != 2'b00);
    endcase
    if (loadMisalign) begin
      loadData = 32'h0;
    end
  end

  // A load misalignment only counts when writeback actually selects load data.
  assign misalignM = storeMisalign | ((ResultSrcM == 2'b01) & loadMisalign);

  // M/W pipeline register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      luipacW    <= 32'h0;
      PCPlus4W   <= 32'h0;
      RDW        <= 5'h0;
      MisalignW  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= loadData;
      luipacW    <= luipacM;
      PCPlus4W   <= PCPlus4M;
      RDW        <= RDM;
      MisalignW  <= misalignM;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed scenarios plus random traffic
// scored against a word-array reference model of the data memory.
module tb_memory_cycle;

  localparam int DL = 8;
  localparam int NW = 1 << DL;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  StoreM = 2'b00, ResultSrcM = 2'b00;
  logic [2:0]  LoadM = 3'b010;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, luipacM = '0, PCPlus4M = '0;
  logic [4:0]  RDM = '0;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, luipacW, PCPlus4W;
  logic [4:0]  RDW;

  int nChecks = 0;
  int nFail = 0;

  logic [31:0] modelMem [NW];
  bit          modelKnown [NW];

  memory_cycle #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .StoreM(StoreM), .LoadM(LoadM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .luipacM(luipacM), .PCPlus4M(PCPlus4M), .RDM(RDM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .luipacW(luipacW), .PCPlus4W(PCPlus4W), .RDW(RDW),
    .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  // Drives one M-stage transaction, clocks it, and scores the W outputs
  // against the reference model. Returns at posedge + 1.
  task automatic mCycle(input logic we, input logic [1:0] st, input logic [2:0] ld,
                        input logic [1:0] rs, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
    int          idx, off, lsize, ssize;
    logic [31:0] word, shifted, expRd;
    bit          known, lmis, smis, expMis;
    logic [63:0] mask;
    logic [104:0] expBundle, gotBundle;
    RegWriteM  = 1'($urandom);
    MemWriteM  = we;
    StoreM     = st;
    LoadM      = ld;
    ResultSrcM = rs;
    ALUResultM = addr;
    WriteDataM = data;
    luipacM    = $urandom;
    PCPlus4M   = $urandom;
    RDM        = 5'($urandom);
    idx = int'(addr / 4) % NW;
    off = int'(addr % 4);
    word = modelMem[idx];
    known = modelKnown[idx];
    shifted = word >> (8 * off);
    lsize = (ld == 3'd0 || ld == 3'd4) ? 1 : (ld == 3'd1 || ld == 3'd5) ? 2 : 4;
    lmis = (off % lsize) != 0;
    if (lsize == 1) begin
      expRd = shifted & 32'hFF;
      if (ld == 3'd0 && expRd >= 32'd128) expRd = expRd + 32'hFFFF_FF00;
    end else if (lsize == 2) begin
      expRd = shifted & 32'hFFFF;
      if (ld == 3'd1 && expRd >= 32'd32768) expRd = expRd + 32'hFFFF_0000;
    end else begin
      expRd = word;
    end
    if (lmis) begin
      expRd = 32'h0;
      known = 1'b1;
    end
    ssize = (st == 2'b01) ? 2 : (st == 2'b10) ? 1 : 4;
    smis = we && ((off % ssize) != 0);
    expMis = smis || (rs == 2'b01 && lmis);
    expBundle = {RegWriteM, ResultSrcM, ALUResultM, luipacM, PCPlus4M, RDM, expMis};
    @(posedge clk);
    #1;
    if (we && !smis) begin
      mask = ((64'd1 << (8 * ssize)) - 64'd1) << (8 * off);
      modelMem[idx] = (modelMem[idx] & ~mask[31:0]) | ((data << (8 * off)) & mask[31:0]);
      modelKnown[idx] = 1'b1;
    end
    gotBundle = {RegWriteW, ResultSrcW, ALUResultW, luipacW, PCPlus4W, RDW, MisalignW};
    nChecks++;
    if (gotBundle !== expBundle) begin
      nFail++;
      $display("FAIL %s W-bundle: got %h required %h", tag, gotBundle, expBundle);
    end
    if (known) begin
      nChecks++;
      if (ReadDataW !== expRd) begin
        nFail++;
        $display("FAIL %s ReadDataW: got %h required %h", tag, ReadDataW, expRd);
      end
    end
    $display("%s we=%b st=%b ld=%b rs=%b addr=%h data=%h -> rd=%h mis=%b",
             tag, we, st, ld, rs, addr, data, ReadDataW, MisalignW);
  endtask

  task automatic test_reset();
    logic [104:0] got;
    #1;
    got = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, luipacW, PCPlus4W, RDW, MisalignW};
    nChecks++;
    if (got !== '0) begin
      nFail++;
      $display("FAIL reset_state: got %h required 0", got);
    end
    repeat (2) @(posedge clk);
    #1;
    got = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, luipacW, PCPlus4W, RDW, MisalignW};
    nChecks++;
    if (got !== '0) begin
      nFail++;
      $display("FAIL reset_hold: got %h required 0", got);
    end
    $display("reset state checked");
    reset = 1'b1;
  endtask

  task automatic test_init_memory();
    for (int i = 0; i < NW; i++) begin
      mCycle(1'b1, 2'b00, 3'b010, 2'b00, 32'(i * 4), $urandom, "init");
    end
  endtask

  task automatic test_word();
    mCycle(1'b1, 2'b00, 3'b010, 2'b00, 32'h10, 32'hDEADBEEF, "sw_word");
    mCycle(1'b0, 2'b00, 3'b010, 2'b01, 32'h10, 32'h0, "lw_word");
    nChecks++;
    if (ReadDataW !== 32'hDEADBEEF || MisalignW !== 1'b0) begin
      nFail++;
      $display("FAIL word_load: got %h/%b required deadbeef/0", ReadDataW, MisalignW);
    end
  endtask

  task automatic test_byte_lanes();
    mCycle(1'b1, 2'b00, 3'b010, 2'b00, 32'h20, 32'h11223344, "sw_base");
    mCycle(1'b1, 2'b10, 3'b010, 2'b00, 32'h21, 32'hFFFFFF80, "sb_lane1");
    mCycle(1'b0, 2'b00, 3'b010, 2'b01, 32'h20, 32'h0, "lw_lanes");
    nChecks++;
    if (ReadDataW !== 32'h11228044) begin
      nFail++;
      $display("FAIL lanes_lw: got %h required 11228044", ReadDataW);
    end
    mCycle(1'b0, 2'b00, 3'b000, 2'b01, 32'h21, 32'h0, "lb_lane1");
    nChecks++;
    if (ReadDataW !== 32'hFFFFFF80) begin
      nFail++;
      $display("FAIL lanes_lb: got %h required ffffff80", ReadDataW);
    end
    mCycle(1'b0, 2'b00, 3'b100, 2'b01, 32'h21, 32'h0, "lbu_lane1");
    nChecks++;
    if (ReadDataW !== 32'h00000080) begin
      nFail++;
      $display("FAIL lanes_lbu: got %h required 00000080", ReadDataW);
    end
  endtask

  task automatic test_half();
    mCycle(1'b1, 2'b01, 3'b010, 2'b00, 32'h32, 32'h12348001, "sh_upper");
    mCycle(1'b0, 2'b00, 3'b001, 2'b01, 32'h32, 32'h0, "lh_upper");
    nChecks++;
    if (ReadDataW !== 32'hFFFF8001) begin
      nFail++;
      $display("FAIL half_lh: got %h required ffff8001", ReadDataW);
    end
    mCycle(1'b0, 2'b00, 3'b101, 2'b01, 32'h32, 32'h0, "lhu_upper");
    nChecks++;
    if (ReadDataW !== 32'h00008001) begin
      nFail++;
      $display("FAIL half_lhu: got %h required 00008001", ReadDataW);
    end
    mCycle(1'b0, 2'b00, 3'b010, 2'b01, 32'h30, 32'h0, "lw_half");
    nChecks++;
    if (ReadDataW[31:16] !== 16'h8001) begin
      nFail++;
      $display("FAIL half_lw_upper: got %h required 8001", ReadDataW[31:16]);
    end
  endtask

  task automatic test_misalign();
    mCycle(1'b1, 2'b00, 3'b010, 2'b00, 32'h40, 32'h55667788, "sw_base40");
    mCycle(1'b1, 2'b00, 3'b010, 2'b00, 32'h41, 32'h99999999, "sw_misaligned");
    nChecks++;
    if (MisalignW !== 1'b1) begin
      nFail++;
      $display("FAIL misalign_store_flag: got %b required 1", MisalignW);
    end
    mCycle(1'b0, 2'b00, 3'b010, 2'b01, 32'h40, 32'h0, "lw_after_mis");
    nChecks++;
    if (ReadDataW !== 32'h55667788 || MisalignW !== 1'b0) begin
      nFail++;
      $display("FAIL misalign_store_effect: got %h/%b required 55667788/0", ReadDataW, MisalignW);
    end
    mCycle(1'b0, 2'b00, 3'b001, 2'b01, 32'h43, 32'h0, "lh_misaligned");
    nChecks++;
    if (ReadDataW !== 32'h0 || MisalignW !== 1'b1) begin
      nFail++;
      $display("FAIL misalign_load: got %h/%b required 0/1", ReadDataW, MisalignW);
    end
  endtask

  task automatic test_wrap_rdw();
    mCycle(1'b1, 2'b00, 3'b010, 2'b00, 32'h0, 32'h12345678, "sw_zero");
    mCycle(1'b1, 2'b00, 3'b010, 2'b00, 32'h400, 32'hA5A5A5A5, "sw_wrap_rdw");
    nChecks++;
    if (ReadDataW !== 32'h12345678) begin
      nFail++;
      $display("FAIL read_during_write: got %h required 12345678", ReadDataW);
    end
    mCycle(1'b0, 2'b00, 3'b010, 2'b01, 32'h0, 32'h0, "lw_wrapped");
    nChecks++;
    if (ReadDataW !== 32'hA5A5A5A5) begin
      nFail++;
      $display("FAIL wrap_load: got %h required a5a5a5a5", ReadDataW);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic        we;
    for (int i = 0; i < 400; i++) begin
      addr = 32'($urandom_range(0, 2047));
      we = 1'($urandom_range(0, 2) == 0);
      mCycle(we, 2'($urandom), 3'($urandom), 2'($urandom), addr, $urandom, "rand");
    end
  endtask

  task automatic test_async_reset();
    logic [104:0] got;
    RegWriteM = 1'b1; MemWriteM = 1'b1; StoreM = 2'b00; LoadM = 3'b010;
    ResultSrcM = 2'b01; ALUResultM = 32'h10; WriteDataM = 32'h0BADF00D;
    luipacM = 32'hCAFE0001; PCPlus4M = 32'h44; RDM = 5'd7;
    #2;
    reset = 1'b0;
    #1;
    got = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, luipacW, PCPlus4W, RDW, MisalignW};
    nChecks++;
    if (got !== '0) begin
      nFail++;
      $display("FAIL async_reset_clear: got %h required 0", got);
    end
    @(posedge clk);
    #1;
    got = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, luipacW, PCPlus4W, RDW, MisalignW};
    nChecks++;
    if (got !== '0) begin
      nFail++;
      $display("FAIL async_reset_hold: got %h required 0", got);
    end
    $display("async reset asserted with store in flight");
    reset = 1'b1;
    mCycle(1'b0, 2'b00, 3'b010, 2'b01, 32'h10, 32'h0, "lw_after_reset");
    nChecks++;
    if (ReadDataW !== 32'hDEADBEEF) begin
      nFail++;
      $display("FAIL reset_store_dropped: got %h required deadbeef", ReadDataW);
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      modelMem[i] = '0;
      modelKnown[i] = 1'b0;
    end
    test_reset();
    test_init_memory();
    test_word();
    test_byte_lanes();
    test_half();
    test_misalign();
    test_wrap_rdw();
    test_random();
    test_word();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory (M) pipeline stage of the five-stage RISC-V core. It sits directly downstream of the execute stage and consumes that stage's M-side register outputs. It contains the data memory: byte, half and word stores use byte-lane enables, and loads are sign- or zero-extended. It also holds the M/W pipeline register that feeds the writeback result mux.

## Interface
Parameters:
- DEPTH_LOG2, 8, log2 of the data memory depth in 32-bit words (256 words by default)

Ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock
- reset, in, 1, asynchronous active-low reset (0 = reset asserted)
- RegWriteM, in, 1, register-file write enable, passed through to W
- MemWriteM, in, 1, store enable
- StoreM, in, 2, store size: 00 sw, 01 sh, 10 sb, 11 treated as sw
- LoadM, in, 3, load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; any other code treated as lw
- ResultSrcM, in, 2, writeback select, passed through to W
- ALUResultM, in, 32, byte address for loads/stores; also passed through as ALU result
- WriteDataM, in, 32, store data; the low byte/half is used for sb/sh
- luipacM, in, 32, LUI/AUIPC value, passed through
- PCPlus4M, in, 32, link value, passed through
- RDM, in, 5, destination register, passed through
- RegWriteW, out, 1, registered RegWriteM
- ResultSrcW, out, 2, registered ResultSrcM
- ALUResultW, out, 32, registered ALUResultM
- ReadDataW, out, 32, registered extended load data
- luipacW, out, 32, registered luipacM
- PCPlus4W, out, 32, registered PCPlus4M
- RDW, out, 5, registered RDM
- MisalignW, out, 1, registered misaligned-access flag

## Operation
- Word index: ALUResultM[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes. Byte offset: ALUResultM[1:0].
- Memory is organised as 4 byte lanes. Lane k holds bits [8k+7:8k], little-endian.
- Stores:
  - sb writes lane = offset with WriteDataM[7:0].
  - sh writes lanes {offset, offset+1} with WriteDataM[15:0]; valid offsets are 0 and 2.
  - sw writes all 4 lanes.
  - Lanes that are not enabled keep their old value.
- Misaligned store: sh with offset[0]=1, or sw with offset≠0. The write is suppressed and the memory is unchanged.
- Loads read the addressed word combinationally. The selected byte/half is picked by offset, then extended:
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw passes the word unchanged.
- Misaligned load: lh/lhu with offset[0]=1, or lw with offset≠0. ReadDataW is 0.
- Misalignment is only evaluated when relevant:
  - For stores, only when MemWriteM=1.
  - For loads, only when ResultSrcM=01 (the load-result select).
  - MisalignM = misaligned store OR misaligned load, and it is registered into MisalignW.
- The load-data path is computed every cycle regardless of ResultSrcM. Only the misalign flag is qualified.
- Memory contents are not affected by reset. Contents are undefined until written.

## Timing
- Store commit: at the rising clk edge where reset=1, MemWriteM=1 and the access is aligned.
- Read-during-write to the same word in the same cycle returns the old data. A load in the cycle after a store returns the new data.
- W outputs have 1-cycle latency: every M input sampled at edge N appears on the W outputs after edge N.
- No stall or flush inputs. The stage advances every cycle.
- Reset:
  - When reset falls to 0, all W outputs go to 0 immediately (RegWriteW=0, ResultSrcW=00, all data outputs 0, RDW=0, MisalignW=0), independent of clk.
  - They stay 0 while reset=0.
  - No store commits while reset=0. A store in flight when reset asserts is dropped.
- First edge after reset deasserts: normal capture and store commit.

## Test plan
- Word store and load: sw 0xDEADBEEF to addr 0x10; next cycle lw 0x10 -> ReadDataW=0xDEADBEEF one cycle later, MisalignW=0.
- Byte lanes: sb 0x80 to 0x21 over an existing 0x11223344 at 0x20:
  - lw 0x20 -> 0x11228044
  - lb 0x21 -> 0xFFFFFF80
  - lbu 0x21 -> 0x00000080
- Half store and signed load: sh 0x8001 to 0x32 -> lh 0x32 = 0xFFFF8001, lhu 0x32 = 0x00008001, lw 0x30 upper half = 0x8001.
- Misalignment:
  - sw to 0x41 -> memory at 0x40 unchanged, MisalignW=1 for exactly one cycle.
  - lh at 0x43 -> ReadDataW=0, MisalignW=1.
- Wrap-around and read-during-write:
  - sw 0xA5A5A5A5 to 0x400 (DEPTH_LOG2=8) -> lw 0x0 returns it.
  - A load of 0x0 in the same cycle as that store returns the old value.
- Reset: assert reset=0 mid-cycle with MemWriteM=1 -> W outputs 0 before the next edge, and the store is not committed. Previously written data is still readable after release.
